// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between two masters.
// Every access runs IDLE -> ACCESS (gnt) -> WAIT (done, read data), 3 cycles.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          op_we_q, op_we_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          winner;

  // On a tie the client that did not win last time goes next.
  assign winner = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    op_we_d     = op_we_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rdata       = rdata_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d     = winner;
          last_d      = winner;
          op_we_d     = winner ? we1 : we0;
          mem_we_d    = winner ? we1 : we0;
          mem_addr_d  = winner ? addr1 : addr0;
          mem_wdata_d = winner ? wdata1 : wdata0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        gnt0    = ~owner_q;
        gnt1    = owner_q;
        state_d = WAIT;
      end
      WAIT: begin
        done0 = ~owner_q;
        done1 = owner_q;
        if (!op_we_q) begin
          rdata   = mem_q;
          rdata_d = mem_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      op_we_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      op_we_q     <= op_we_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked by
// a transaction-level model feeding grant/completion scoreboard queues.
module tb_mem_port_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, done0, gnt1, done1, mem_we, busy;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [15:0] mem_q;

  always #5 Clock = ~Clock;

  mem_port_arbiter #(.AW(16), .DW(16)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_q(mem_q), .busy(busy)
  );

  // Synchronous memory, one-cycle read latency, indexed by low address byte.
  logic [15:0] mem [256];
  always @(posedge Clock) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_q <= mem[mem_addr[7:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          c;
    bit          we;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] r;
  } txn_t;

  txn_t gq[$];
  txn_t dq[$];

  // Reference model: one transaction at a time, 3 cycles each, round-robin ties.
  logic [15:0] mmem [256];
  int          m_cnt = 0;
  bit          m_last = 1'b1;
  bit          m_owner = 1'b0;
  bit          m_we = 1'b0;
  logic [15:0] m_rd = 16'h0;

  always @(posedge Clock) begin
    txn_t t;
    bit   w;
    if (!Resetn) begin
      m_cnt = 0; m_last = 1'b1; m_rd = 16'h0; m_we = 1'b0;
      gq.delete(); dq.delete();
    end else if (m_cnt != 0) begin
      m_cnt--;
    end else if (req0 || req1) begin
      w    = (req0 && req1) ? !m_last : req1;
      t.c  = w;
      t.we = w ? we1 : we0;
      t.a  = w ? addr1 : addr0;
      t.d  = w ? wdata1 : wdata0;
      t.r  = t.we ? m_rd : mmem[t.a[7:0]];
      if (t.we) mmem[t.a[7:0]] = t.d;
      else m_rd = t.r;
      gq.push_back(t);
      m_cnt = 2; m_last = w; m_owner = w; m_we = t.we;
    end
  end

  bit chk_en = 1'b0;

  // Monitor: per-cycle control outputs plus scoreboard pops on gnt/done.
  always @(negedge Clock) begin
    txn_t t;
    logic [5:0] exp_v;
    if (chk_en) begin
      exp_v = {m_cnt != 0,
               m_cnt == 2 && !m_owner, m_cnt == 2 && m_owner,
               m_cnt == 1 && !m_owner, m_cnt == 1 && m_owner,
               m_cnt == 2 && m_we};
      check("ctrl{busy,gnt0,gnt1,done0,done1,mem_we}",
            {58'd0, busy, gnt0, gnt1, done0, done1, mem_we}, {58'd0, exp_v});
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) check("unexpected_gnt", 1, 0);
        else begin
          t = gq.pop_front();
          check("gnt_client", {63'd0, gnt1}, {63'd0, t.c});
          check("mem_addr", {48'd0, mem_addr}, {48'd0, t.a});
          if (t.we) check("mem_wdata", {48'd0, mem_wdata}, {48'd0, t.d});
          dq.push_back(t);
        end
      end
      if (done0 || done1) begin
        if (dq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          t = dq.pop_front();
          check("done_client", {63'd0, done1}, {63'd0, t.c});
          check(t.we ? "rdata_held" : "rdata", {48'd0, rdata}, {48'd0, t.r});
        end
      end
    end
  end

  // Random clients: hold request until gnt, then either drop or issue a new one.
  bit rand_en = 1'b0;
  bit drain   = 1'b0;

  always @(negedge Clock) if (rand_en) begin
    if ((req0 && gnt0) || !req0) begin
      if (!drain && (req0 ? $urandom_range(1, 0) == 1 : $urandom_range(3, 0) == 0)) begin
        req0 = 1'b1; we0 = $urandom_range(1, 0) == 1;
        addr0 = 16'($urandom); wdata0 = 16'($urandom);
      end else req0 = 1'b0;
    end
    if ((req1 && gnt1) || !req1) begin
      if (!drain && (req1 ? $urandom_range(1, 0) == 1 : $urandom_range(3, 0) == 0)) begin
        req1 = 1'b1; we1 = $urandom_range(1, 0) == 1;
        addr1 = 16'($urandom); wdata1 = 16'($urandom);
      end else req1 = 1'b0;
    end
  end

  task automatic wait_gnt(input bit c);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clock);
      seen = c ? gnt1 : gnt0;
    end
    if (!seen) check(c ? "gnt1_timeout" : "gnt0_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] v;
    Resetn = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom); mem[i] = v; mmem[i] = v;
    end
    mem[8'h10] = 16'hBEEF; mmem[8'h10] = 16'hBEEF;

    repeat (2) @(negedge Clock);
    chk_en = 1'b1;
    check("reset_rdata", {48'd0, rdata}, 64'd0);
    check("reset_mem_addr", {48'd0, mem_addr}, 64'd0);
    check("reset_mem_wdata", {48'd0, mem_wdata}, 64'd0);
    Resetn = 1'b1;
    repeat (10) @(negedge Clock);

    // Single read by client 0.
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    wait_gnt(0);
    req0 = 0;
    repeat (4) @(negedge Clock);

    // Single write by client 1.
    req1 = 1; we1 = 1; addr1 = 16'h0020; wdata1 = 16'h1234;
    wait_gnt(1);
    req1 = 0;
    repeat (4) @(negedge Clock);

    // Both clients requesting continuously.
    req0 = 1; we0 = 0; addr0 = 16'h1003;
    req1 = 1; we1 = 0; addr1 = 16'h2004;
    repeat (12) @(negedge Clock);
    req0 = 0; req1 = 0;
    repeat (4) @(negedge Clock);

    // Late request from client 1 during client 0's ACCESS.
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    wait_gnt(0);
    req0 = 0;
    req1 = 1; we1 = 0; addr1 = 16'h0020;
    wait_gnt(1);
    req1 = 0;
    repeat (4) @(negedge Clock);

    // Reset during a client 0 write; afterwards client 0 must win the tie.
    req0 = 1; we0 = 1; addr0 = 16'h0055; wdata0 = 16'hA5A5;
    wait_gnt(0);
    req0 = 0;
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    check("post_reset_mem_we", {63'd0, mem_we}, 64'd0);
    req0 = 1; we0 = 0; addr0 = 16'h0055;
    req1 = 1; we1 = 0; addr1 = 16'h0010;
    wait_gnt(0);
    req0 = 0;
    wait_gnt(1);
    req1 = 0;
    repeat (4) @(negedge Clock);

    // Random traffic, then drain.
    rand_en = 1'b1;
    repeat (3000) @(negedge Clock);
    drain = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!req0 && !req1 && m_cnt == 0 && gq.size() == 0 && dq.size() == 0) break;
      @(negedge Clock);
    end
    rand_en = 1'b0;
    check("drain_idle", {62'd0, req0 || req1, m_cnt != 0}, 64'd0);
    check("queues_empty", gq.size() + dq.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single synchronous program/data memory port between two bus masters. Client 0 is the processor's load/store/fetch path; client 1 is a DMA/loader engine that writes program images or moves data.
The block arbitrates round-robin, sequences each access through the memory's one-cycle read latency, and returns read data with a completion pulse. It sits between the masters and the memory's address, data, write-enable and q pins.

Parameters:
AW, 16, address width
DW, 16, data width

Ports:
Clock  in  1  system clock, all state updates on rising edge
Resetn  in  1  synchronous, active-low reset
req0  in  1  client 0 access request
we0  in  1  client 0 write (1) / read (0)
addr0  in  AW  client 0 address
wdata0  in  DW  client 0 write data
gnt0  out  1  client 0 request accepted (1-cycle pulse)
done0  out  1  client 0 access complete; rdata valid if read (1-cycle pulse)
req1, we1, addr1, wdata1  in  1/1/AW/DW  client 1, same meaning as client 0
gnt1, done1  out  1/1  client 1, same meaning as client 0
rdata  out  DW  read data, valid only in the cycle done0/done1 is high
mem_addr  out  AW  registered memory address
mem_wdata  out  DW  registered memory write data
mem_we  out  1  registered memory write enable
mem_q  in  DW  memory read data, valid one cycle after the address is sampled
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (Resetn=0 at a rising edge):
  - state=IDLE; gnt0/1, done0/1, mem_we and busy all 0.
  - mem_addr=0, mem_wdata=0, rdata=0.
  - Round-robin pointer last=1, so client 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT. Each transaction takes exactly 3 cycles; throughput is 1 access per 3 cycles.
- IDLE:
  - Requests are sampled only in IDLE.
  - If neither req is high: stay in IDLE.
  - If exactly one req is high: that client wins.
  - If both are high: the client != last wins.
  - On a win: register mem_addr, mem_wdata and mem_we from the winner's inputs, set owner=winner and last=winner, then go to ACCESS.
- ACCESS:
  - gnt_owner=1 for this cycle only.
  - mem_* are held stable and the memory samples them at the end of this cycle.
  - mem_we=1 only in this cycle, and only for writes.
  - Next state: WAIT.
- WAIT:
  - mem_we=0; mem_addr is held.
  - done_owner=1 for this cycle; rdata=mem_q combinationally for reads, and rdata is held at its previous value for writes.
  - Next state: IDLE.
- Client rules:
  - A client holds req, we, addr and wdata stable until it sees gnt. It may drop req in the gnt cycle.
  - A req held high through done is treated as a new request in the following IDLE.
- Fairness: with both clients continuously requesting, grants alternate 0,1,0,1… Neither client ever waits more than one transaction.
- A req that rises during ACCESS or WAIT is not lost; it is picked up in the next IDLE if still asserted.
- A req withdrawn in IDLE before being sampled produces no grant.
- gnt and done are never high for both clients at once. gnt and done of the same client are never high in the same cycle.
- Reset mid-operation (ACCESS or WAIT): the transaction is abandoned.
  - No done is issued and mem_we drops to 0 at that edge.
  - A write sampled by memory in a completed ACCESS cycle is not undone.
- Addresses and data pass through unmodified: no wrap, no width conversion.

Test Plan:
- Reset then idle: Resetn=0 for 2 cycles, no reqs -> busy=0, mem_we=0, gnt/done all 0 for 10 cycles.
- Single read client 0: addr0=0x0010, mem_q returns 0xBEEF -> gnt0 in cycle+1, mem_addr=0x0010, done0 in cycle+2 with rdata=0xBEEF, mem_we never 1.
- Single write client 1: addr1=0x0020, wdata1=0x1234, we1=1 -> mem_we=1 exactly one cycle with mem_addr=0x0020, mem_wdata=0x1234; done1 one cycle later.
- Simultaneous reqs held continuously for 12 cycles: after reset -> grants ordered 0,1,0,1 with done pulses every 3 cycles and no overlap of gnt0/gnt1.
- Late request: req1 rises during client 0's ACCESS -> client 1 is granted in the ACCESS cycle following the next IDLE, and no access is dropped.
- Reset in ACCESS of a write: Resetn=0 in the cycle gnt0=1 -> next cycle state IDLE, done0 never asserted, mem_we=0, pointer last=1.
